// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word width, fetch FSM encoding and the sequential PC step.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_INCR = 32'd4;

    // Sequential successor of a fetch address; wraps modulo 2^32.
    function automatic word_t next_seq_pc(input word_t pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters: delivered instructions and front-end idle request cycles.
module fetch_perf_ctr
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  fetch_valid,
    input  logic  req_waiting,
    output word_t fetch_count,
    output word_t stall_count
);

    word_t fetch_count_reg;
    word_t stall_count_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_count_reg <= '0;
            stall_count_reg <= '0;
        end else begin
            if (fetch_valid) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
            if (req_waiting) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_reg;
    assign stall_count = stall_count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, talks to the icache and feeds the IF/ID latch.
// Optional counters are built when FETCH_PERF_EN is defined.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_RESET = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  ihit,
    input  word_t imemload,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    output word_t instr_out,
    output word_t pc_out,
    output word_t pcplusfour_out,
    output logic  ihit_out,
`ifdef FETCH_PERF_EN
    output word_t fetch_count,
    output word_t stall_count,
`endif
    output logic  halted
);

    word_t        pc_reg;
    word_t        redirect_q_reg;
    fetch_state_t state_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_reg         <= PC_RESET;
            redirect_q_reg <= '0;
            state_reg      <= FETCH;
        end else begin
            unique case (state_reg)
                FETCH: begin
                    if (halt) begin
                        state_reg <= HALTED;
                    end else if (redirect) begin
                        if (ihit) begin
                            pc_reg <= redirect_pc;
                        end else begin
                            // A request is in flight; park the target until it returns.
                            redirect_q_reg <= redirect_pc;
                            state_reg      <= SQUASH;
                        end
                    end else if (ihit && !stall) begin
                        pc_reg <= next_seq_pc(pc_reg);
                    end
                end
                SQUASH: begin
                    if (halt) begin
                        state_reg <= HALTED;
                    end else if (redirect) begin
                        redirect_q_reg <= redirect_pc;
                        if (ihit) begin
                            pc_reg    <= redirect_pc;
                            state_reg <= FETCH;
                        end
                    end else if (ihit) begin
                        pc_reg    <= redirect_q_reg;
                        state_reg <= FETCH;
                    end
                end
                HALTED: begin
                    state_reg <= HALTED;
                end
                default: begin
                    state_reg <= FETCH;
                end
            endcase
        end
    end

    // No output register here: the IF/ID latch is the pipeline stage.
    assign imemaddr       = pc_reg;
    assign imemREN        = (state_reg != HALTED);
    assign instr_out      = imemload;
    assign pc_out         = pc_reg;
    assign pcplusfour_out = next_seq_pc(pc_reg);
    assign ihit_out       = (state_reg == FETCH) && ihit && !stall && !redirect && !halt;
    assign halted         = (state_reg == HALTED);

`ifdef FETCH_PERF_EN
    fetch_perf_ctr u_perf (
        .CLK         (CLK),
        .nRST        (nRST),
        .fetch_valid (ihit_out),
        .req_waiting (imemREN && !ihit_out),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage producer feeding the IF/ID pipeline latch. It owns the PC register, issues instruction reads to the icache, and presents the fetched word with its PC and PC+4. It qualifies the result with a valid strobe (ihit_out) and handles redirects from branch/jump resolution and processor halt. All its outputs connect directly to the latch's *_in ports.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset.
WORD_W, 32, instruction/address width (taken from the shared package; not overridden).

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous, active-low reset.
imemREN  out  1  icache read request.
imemaddr  out  32  icache read address (equals the current fetch PC).
ihit  in  1  icache hit; imemload is valid this cycle.
imemload  in  32  instruction word from the icache.
stall  in  1  hazard unit holds the front end; no PC advance, no valid output.
redirect  in  1  branch/jump resolved; fetch must restart at redirect_pc.
redirect_pc  in  32  redirect target (word aligned).
halt  in  1  halt retired; fetch stops permanently until reset.
instr_out  out  32  to IF/ID instr_in.
pc_out  out  32  to IF/ID pc_in.
pcplusfour_out  out  32  to IF/ID pcplusfour_in.
ihit_out  out  1  to IF/ID ihit_in; the instruction is valid and consumed.
halted  out  1  fetch is in the HALTED state.

Behaviour:
- Registered state: pc (32), redirect_q (32), state ∈ {FETCH, SQUASH, HALTED}.
- Reset (async, nRST=0):
  - pc=PC_RESET, redirect_q=0, state=FETCH.
  - Resulting outputs: imemREN=1, imemaddr=PC_RESET, ihit_out=0 until the first ihit, halted=0.
- Outputs are combinational from the registered state and current inputs; there is zero added latency, because the IF/ID latch provides the pipeline register.
  - imemaddr = pc.
  - imemREN = (state != HALTED).
  - instr_out = imemload.
  - pc_out = pc.
  - pcplusfour_out = pc + 4, computed modulo 2^32 (0xFFFF_FFFC+4 wraps to 0).
  - ihit_out = (state==FETCH) & ihit & ~stall & ~redirect & ~halt.
  - halted = (state==HALTED).
- Priority per cycle: halt > redirect > ihit/stall.
- FETCH state:
  - halt → HALTED.
  - redirect & ihit → pc<=redirect_pc; the fetched word is discarded; stay in FETCH.
  - redirect & ~ihit → redirect_q<=redirect_pc, go to SQUASH. The address must not change while a request is outstanding.
  - ihit & ~stall → pc<=pc+4.
  - ihit & stall → pc holds; the same address is re-requested next cycle.
  - ~ihit → hold.
- SQUASH state:
  - imemREN stays 1 and imemaddr stays at the old pc; ihit_out is forced to 0.
  - redirect → redirect_q<=redirect_pc (the newest target wins). If ihit is also high in that cycle, pc<=redirect_pc directly and go to FETCH.
  - ihit → pc<=redirect_q, go to FETCH.
  - halt → HALTED (abandoning the request is legal).
- HALTED state:
  - imemREN=0, ihit_out=0; pc frozen.
  - Only nRST exits this state.
- Reset asserted mid-SQUASH: redirect_q is lost and fetch restarts at PC_RESET.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds output ports fetch_count[31:0] and stall_count[31:0], both reset to 0 and wrapping at 2^32.
  - fetch_count increments on every cycle with ihit_out=1.
  - stall_count increments on every cycle with imemREN=1 & ihit_out=0.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg holds:
  - word_t (32-bit) and WORD_W.
  - fetch_state_t enum {FETCH, SQUASH, HALTED}.
  - the PC increment constant (4).
- Sub-module: fetch_perf_ctr (the two counters), instantiated only under FETCH_PERF_EN. The PC and state logic stays in fetch_unit.

Test Plan:
- Reset then ihit=1 every cycle, imemload=0x2001_0005:
  - pc_out sequence is 0,4,8,C, with ihit_out=1 each cycle.
  - pcplusfour_out sequence is 4,8,C,10.
- Cache latency, ihit low for 3 cycles then high:
  - imemaddr is held at 0x0 and ihit_out=0 for 3 cycles.
  - Then ihit_out=1 for one cycle and pc advances to 0x4.
- stall=1 with ihit=1 at pc=0x8 for 2 cycles:
  - ihit_out=0 and pc stays 0x8.
  - After stall drops, ihit_out=1 with pc_out=0x8.
- redirect=1, redirect_pc=0x100 while ihit=0 at pc=0x10:
  - Enters SQUASH; imemaddr stays 0x10.
  - A second redirect to 0x200 arrives; when ihit arrives, ihit_out stays 0.
  - Next cycle imemaddr=0x200.
- redirect and halt in the same cycle:
  - Enters HALTED; imemREN=0 and halted=1 persist for 10 cycles.
  - nRST pulse returns pc to 0x0 with imemREN=1.
- With FETCH_PERF_EN, 5 hits and 3 miss cycles: fetch_count=5, stall_count=3. Reset clears both.
